// File: rtl/spi_pkg.sv
// Shared SPI slave control definitions: state encodings, enable bundle
// and the default word width.
package spi_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_GET_ADDR     = 3'd1;
    localparam logic [2:0] ST_LATCH_ADDR   = 3'd2;
    localparam logic [2:0] ST_READ_LOAD    = 3'd3;
    localparam logic [2:0] ST_READ_SHIFT   = 3'd4;
    localparam logic [2:0] ST_WRITE_RECV   = 3'd5;
    localparam logic [2:0] ST_WRITE_COMMIT = 3'd6;
    localparam logic [2:0] ST_DONE         = 3'd7;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        GET_ADDR     = ST_GET_ADDR,
        LATCH_ADDR   = ST_LATCH_ADDR,
        READ_LOAD    = ST_READ_LOAD,
        READ_SHIFT   = ST_READ_SHIFT,
        WRITE_RECV   = ST_WRITE_RECV,
        WRITE_COMMIT = ST_WRITE_COMMIT,
        DONE         = ST_DONE
    } stateT;

    typedef struct packed {
        logic addrWE;
        logic dmWE;
        logic srWE;
        logic misoBufe;
    } enablesT;

    // Moore decode: each enable belongs to exactly one state.
    function automatic enablesT decodeEnables(input stateT s);
        enablesT e;
        e = '0;
        unique case (s)
            LATCH_ADDR:   e.addrWE   = 1'b1;
            READ_LOAD:    e.srWE     = 1'b1;
            READ_SHIFT:   e.misoBufe = 1'b1;
            WRITE_COMMIT: e.dmWE     = 1'b1;
            default:      e          = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Saturating bit counter for the SPI control FSM; done flags WIDTH
// counted edges and further increments are ignored.
module bit_counter
    import spi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          done
);

    assign done = (count == CW'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction controller: address phase, then a read or write
// data phase, with registered Moore enables and chip-select abort.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csN,
    input  logic             sclkPosEdge,
    input  logic             sclkNegEdge,
    input  logic [WIDTH-1:0] shiftRegOutP,
    output logic             addrWE,
    output logic             dmWE,
    output logic             srWE,
    output logic             misoBufe,
    output logic [2:0]       state
);

    localparam int CW = $clog2(WIDTH) + 1;

    stateT         curState;
    stateT         nextState;
    enablesT       en;
    logic          cntClear;
    logic          cntInc;
    logic          cntDone;
    logic [CW-1:0] bitCount;
    logic          unusedBits;

    assign unusedBits = ^{shiftRegOutP[WIDTH-1:1], bitCount};

    bit_counter #(
        .WIDTH(WIDTH)
    ) uCounter (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(cntClear),
        .inc  (cntInc),
        .count(bitCount),
        .done (cntDone)
    );

    // Only the three shifting states hold a count; all others keep it at 0.
    assign cntClear = csN || !(curState inside {GET_ADDR, READ_SHIFT, WRITE_RECV});

    always_comb begin
        cntInc = 1'b0;
        unique case (1'b1)
            (curState == GET_ADDR):   cntInc = sclkPosEdge;
            (curState == WRITE_RECV): cntInc = sclkPosEdge;
            (curState == READ_SHIFT): cntInc = sclkNegEdge;
            default:                  cntInc = 1'b0;
        endcase
    end

    always_comb begin
        nextState = curState;
        if (csN) begin
            nextState = IDLE;
        end else begin
            unique case (curState)
                IDLE:         nextState = GET_ADDR;
                GET_ADDR:     if (cntDone) nextState = LATCH_ADDR;
                LATCH_ADDR:   nextState = shiftRegOutP[0] ? READ_LOAD : WRITE_RECV;
                READ_LOAD:    nextState = READ_SHIFT;
                READ_SHIFT:   if (cntDone) nextState = DONE;
                WRITE_RECV:   if (cntDone) nextState = WRITE_COMMIT;
                WRITE_COMMIT: nextState = DONE;
                DONE:         nextState = DONE;
                default:      nextState = IDLE;
            endcase
        end
    end

    // Enables are decoded from the next state so they line up with entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= IDLE;
            en       <= '0;
        end else begin
            curState <= nextState;
            en       <= decodeEnables(nextState);
        end
    end

    assign addrWE   = en.addrWE;
    assign dmWE     = en.dmWE;
    assign srWE     = en.srWE;
    assign misoBufe = en.misoBufe;
    assign state    = curState;

endmodule

// File: tb/tb_spi_fsm.sv
// Randomized scoreboard bench for spi_fsm: a transaction-level model
// queues the expected enable pulses and a negedge monitor checks them.
module tb_spi_fsm;
    import spi_pkg::*;

    localparam int W = WIDTH_DEF;

    localparam int EV_ADDR = 0;
    localparam int EV_SRWE = 1;
    localparam int EV_DMWE = 2;
    localparam int EV_MISO = 3;
    localparam int EV_DONE = 4;
    localparam int EV_IDLE = 5;

    typedef struct {
        int kind;
        int len;
        int edges;
    } evT;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         csN;
    logic         sclkPosEdge;
    logic         sclkNegEdge;
    logic [W-1:0] shiftRegOutP;
    logic         addrWE;
    logic         dmWE;
    logic         srWE;
    logic         misoBufe;
    logic [2:0]   state;

    int checks = 0;
    int errors = 0;
    evT expQ[$];

    spi_fsm #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csN         (csN),
        .sclkPosEdge (sclkPosEdge),
        .sclkNegEdge (sclkNegEdge),
        .shiftRegOutP(shiftRegOutP),
        .addrWE      (addrWE),
        .dmWE        (dmWE),
        .srWE        (srWE),
        .misoBufe    (misoBufe),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushEv(input int kind, input int len, input int edges);
        evT e;
        e.kind  = kind;
        e.len   = len;
        e.edges = edges;
        expQ.push_back(e);
    endtask

    task automatic emit(input int kind, input int len, input int edges);
        evT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event: got kind %0d, expected none", kind);
        end else begin
            e = expQ.pop_front();
            chk("event kind", kind, e.kind);
            if (e.len >= 0) chk("event length", len, e.len);
            if (e.edges >= 0) chk("event edge count", edges, e.edges);
        end
    endtask

    // Monitor: turns enable waveforms into pulse/window events.
    int   addrLen = 0, srLen = 0, dmLen = 0, misoLen = 0, misoNegs = 0;
    int   posSeen = 0, addrPos = 0, dmPos = 0;
    logic pA = 0, pS = 0, pD = 0, pM = 0;
    logic [2:0] pState = ST_IDLE;

    always @(negedge clk) begin
        if (sclkPosEdge && !csN) posSeen++;
        if (addrWE && !pA) begin
            addrPos = posSeen;
            posSeen = 0;
        end
        if (dmWE && !pD) dmPos = posSeen;
        if (addrWE) addrLen++;
        if (srWE) srLen++;
        if (dmWE) dmLen++;
        if (misoBufe) misoLen++;
        if (misoBufe && sclkNegEdge) misoNegs++;
        if (!addrWE && pA) begin
            emit(EV_ADDR, addrLen, addrPos);
            addrLen = 0;
        end
        if (!srWE && pS) begin
            emit(EV_SRWE, srLen, -1);
            srLen = 0;
        end
        if (!dmWE && pD) begin
            emit(EV_DMWE, dmLen, dmPos);
            dmLen = 0;
        end
        if (!misoBufe && pM) begin
            emit(EV_MISO, misoLen, misoNegs);
            misoLen  = 0;
            misoNegs = 0;
        end
        if (state == ST_DONE && pState != ST_DONE)
            emit(EV_DONE, int'({addrWE, srWE, dmWE, misoBufe}), -1);
        if (state == ST_IDLE && pState != ST_IDLE) begin
            emit(EV_IDLE, -1, -1);
            posSeen = 0;
        end
        pA     = addrWE;
        pS     = srWE;
        pD     = dmWE;
        pM     = misoBufe;
        pState = state;
    end

    task automatic sendPulse(input logic p, input logic n);
        sclkPosEdge = p;
        sclkNegEdge = n;
        @(posedge clk);
        #1;
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitState(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (state != target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, int'(state), int'(target));
    endtask

    task automatic chkIdleQuiet(input string name);
        chk({name, " state"}, int'(state), int'(ST_IDLE));
        chk({name, " enables"}, int'({addrWE, srWE, dmWE, misoBufe}), 0);
        chk({name, " counter"}, int'(dut.uCounter.count), 0);
    endtask

    // abortAfter < 0: full transaction; otherwise a write aborted by csN
    // after that many data posedges.
    task automatic doTxn(input logic [W-1:0] addr, input int abortAfter);
        bit isRead;
        int n;
        isRead = addr[0];
        pushEv(EV_ADDR, 1, W);
        if (abortAfter >= 0) begin
            pushEv(EV_IDLE, -1, -1);
        end else if (isRead) begin
            pushEv(EV_SRWE, 1, -1);
            pushEv(EV_MISO, -1, W);
            pushEv(EV_DONE, 0, -1);
            pushEv(EV_IDLE, -1, -1);
        end else begin
            pushEv(EV_DMWE, 1, W);
            pushEv(EV_DONE, 0, -1);
            pushEv(EV_IDLE, -1, -1);
        end

        shiftRegOutP = addr;
        csN = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 3) == 0) sendPulse(1'b0, 1'b1);
            sendPulse(1'b1, 1'($urandom_range(0, 1)));
        end
        waitState(isRead ? ST_READ_SHIFT : ST_WRITE_RECV, 8, "data phase entry");
        shiftRegOutP = W'($urandom);

        if (isRead) begin
            for (int i = 0; i < W; i++) sendPulse(1'($urandom_range(0, 1)), 1'b1);
            waitState(ST_DONE, 8, "read reaches DONE");
        end else begin
            n = (abortAfter >= 0) ? abortAfter : W;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) sendPulse(1'b0, 1'b1);
                sendPulse(1'b1, 1'($urandom_range(0, 1)));
            end
            if (abortAfter >= 0) begin
                csN = 1'b1;
                @(posedge clk);
                #1;
                chk("abort to IDLE", int'(state), int'(ST_IDLE));
                chk("abort dmWE", int'(dmWE), 0);
                return;
            end
            waitState(ST_DONE, 8, "write reaches DONE");
        end

        repeat (2) sendPulse(1'b1, 1'b1);
        chk("DONE holds", int'(state), int'(ST_DONE));
        chk("DONE counter", int'(dut.uCounter.count), 0);
        csN = 1'b1;
        @(posedge clk);
        #1;
        chk("csN ends txn", int'(state), int'(ST_IDLE));
    endtask

    task automatic resetMid();
        pushEv(EV_IDLE, -1, -1);
        shiftRegOutP = W'($urandom);
        csN = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) sendPulse(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chkIdleQuiet("async reset");
        csN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chkIdleQuiet("reset release");
        @(posedge clk);
        #1;
        chk("idle after release", int'(state), int'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        csN          = 1'b1;
        sclkPosEdge  = 1'b0;
        sclkNegEdge  = 1'b0;
        shiftRegOutP = '0;
        #12;
        chkIdleQuiet("power-on reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (4) sendPulse(1'b1, 1'($urandom_range(0, 1)));
        chkIdleQuiet("spurious edges in IDLE");

        doTxn(8'b0000_0110, -1);
        doTxn(8'b0000_0111, -1);
        doTxn(W'($urandom) & ~W'(1), 5);
        resetMid();

        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] a;
            a = W'($urandom);
            if (!a[0] && $urandom_range(0, 3) == 0)
                doTxn(a, int'($urandom_range(1, W - 1)));
            else
                doTxn(a, -1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
